// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: start/done FSM driving data_path strobes for Ra <= Rb op Rc; ALU_SEQ_MULDIV_EN adds MUL/DIV HI/LO path
module alu_op_sequencer (
  input  logic        Clock,
  input  logic        clear,
  input  logic        start,
  input  logic [4:0]  opcode,
  input  logic [3:0]  ra,
  input  logic [3:0]  rb,
  input  logic [3:0]  rc,
  output logic [15:0] Rout,
  output logic [15:0] Rin,
  output logic        Yin,
  output logic        Zlowin,
  output logic        ZHighin,
  output logic        Zlowout,
  output logic        Zhighout,
  output logic        HIin,
  output logic        LOin,
  output logic [4:0]  op,
  output logic        busy,
  output logic        done,
  output logic        err
);
  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] T_Y  = 3'd1;
  localparam logic [2:0] T_OP = 3'd2;
  localparam logic [2:0] T_WB = 3'd3;
  localparam logic [2:0] ERR  = 3'd5;
`ifdef ALU_SEQ_MULDIV_EN
  localparam logic [2:0] T_WB_HI = 3'd4;
`endif
  logic [2:0] state_q, state_d;
  logic [4:0] opc_q;
  logic [3:0] ra_q, rb_q, rc_q;
  logic       unary_in, illegal_in, unary_q, md;
  assign unary_in = (opcode == 5'd17) || (opcode == 5'd18);
  assign unary_q  = (opc_q == 5'd17) || (opc_q == 5'd18);
`ifdef ALU_SEQ_MULDIV_EN
  assign illegal_in = opcode > 5'd18;
  assign md         = (opc_q == 5'd15) || (opc_q == 5'd16);
`else
  assign illegal_in = (opcode > 5'd14) && !unary_in;
  assign md         = 1'b0;
`endif
  always_comb begin
    state_d = (state_q == IDLE) ? (start ? (illegal_in ? ERR : unary_in ? T_OP : T_Y) : IDLE)
            : (state_q == T_Y)  ? T_OP
            : (state_q == T_OP) ? T_WB
`ifdef ALU_SEQ_MULDIV_EN
            : (state_q == T_WB && md) ? T_WB_HI
`endif
            : IDLE;
  end
  always_ff @(posedge Clock) begin
    if (clear) begin
      state_q <= IDLE;
      opc_q   <= '0;
      ra_q    <= '0;
      rb_q    <= '0;
      rc_q    <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && start) begin
        opc_q <= opcode;
        ra_q  <= ra;
        rb_q  <= rb;
        rc_q  <= rc;
      end
    end
  end
  assign Rout    = (state_q == T_Y)  ? (16'd1 << rb_q)
                 : (state_q == T_OP) ? (16'd1 << (unary_q ? rb_q : rc_q)) : 16'd0;
  assign Rin     = (state_q == T_WB && !md) ? (16'd1 << ra_q) : 16'd0;
  assign Yin     = state_q == T_Y;
  assign Zlowin  = state_q == T_OP;
  assign Zlowout = state_q == T_WB;
`ifdef ALU_SEQ_MULDIV_EN
  assign ZHighin  = (state_q == T_OP) && md;
  assign LOin     = (state_q == T_WB) && md;
  assign Zhighout = state_q == T_WB_HI;
  assign HIin     = state_q == T_WB_HI;
  assign done     = ((state_q == T_WB) && !md) || (state_q == T_WB_HI);
`else
  assign ZHighin  = 1'b0;
  assign LOin     = 1'b0;
  assign Zhighout = 1'b0;
  assign HIin     = 1'b0;
  assign done     = state_q == T_WB;
`endif
  assign op   = (state_q != IDLE && state_q != ERR) ? opc_q : 5'd0;
  assign busy = state_q != IDLE;
  assign err  = state_q == ERR;
endmodule

// File: doc/alu_op_sequencer.md
# alu_op_sequencer

Control-unit FSM that runs one register-to-register ALU instruction (`Ra <= Rb op Rc`) on the mini-CPU `data_path` by driving its bus-select and register-load strobes cycle by cycle. It replaces hand-sequenced testbench strobes with a start/done handshake. It sits between the instruction decode logic and `data_path`: register out-strobes, register in-strobes, Y/Z/HI/LO strobes and `op`.

## Interface
- No parameters. Register file is fixed at 16 × 32-bit; opcode width is fixed at 5.
- `Clock` in 1: system clock, rising edge.
- `clear` in 1: synchronous, active-high reset.
- `start` in 1: request to execute one operation; sampled only in IDLE.
- `opcode` in 5: ALU operation code.
- `ra` in 4: destination register index.
- `rb` in 4: first source register index.
- `rc` in 4: second source register index.
- `Rout` out 16: one-hot register bus-select (`R0out`..`R15out`).
- `Rin` out 16: one-hot register load (`R0in`..`R15in`).
- `Yin`, `Zlowin`, `ZHighin`, `Zlowout`, `Zhighout`, `HIin`, `LOin` out 1 each: datapath strobes.
- `op` out 5: ALU operation presented to `data_path`.
- `busy` out 1: high in every state except IDLE.
- `done` out 1: one-cycle pulse in the last cycle of a legal operation.
- `err` out 1: one-cycle pulse when an illegal opcode is rejected.

## Operation
- Opcode classes:
  - Binary: 5'b00000–5'b01110, e.g. ROL = 5'b00110.
  - MUL: 5'b01111. DIV: 5'b10000.
  - Unary: NEG = 5'b10001, NOT = 5'b10010.
  - Illegal: 5'b10011–5'b11111.
- On `start` in IDLE, latch `opcode`, `ra`, `rb`, `rc`. Later changes to these inputs are ignored until the sequencer returns to IDLE.
- States and per-state outputs:
  - IDLE: all strobes 0; `op` = 0.
  - T_Y: `Rout[rb]`, `Yin`.
  - T_OP: `Rout[rc]` for binary/MUL/DIV, or `Rout[rb]` for unary; `Zlowin`; `ZHighin` additionally for MUL/DIV.
  - T_WB: `Zlowout`; `Rin[ra]` for binary/unary, or `LOin` for MUL/DIV; `done` for binary/unary.
  - T_WB_HI: `Zhighout`, `HIin`, `done`.
  - ERR: `err` only.
- Transitions:
  - IDLE → T_Y for binary/MUL/DIV start.
  - IDLE → T_OP for unary start.
  - IDLE → ERR for illegal start.
  - T_Y → T_OP.
  - T_OP → T_WB.
  - T_WB → IDLE for binary/unary.
  - T_WB → T_WB_HI for MUL/DIV.
  - T_WB_HI → IDLE.
  - ERR → IDLE.
- `op` equals the latched opcode in every non-IDLE, non-ERR state and is 0 otherwise.
- Strobe rules:
  - At most one `Rout` bit and at most one bus driver (`Rout`/`Zlowout`/`Zhighout`) are high in any cycle.
  - `Rin` is one-hot or zero.
- `ra` may equal `rb` or `rc`, and R0 is a legal destination. The sequencer performs no hazard handling.

## Timing
- All outputs are decoded from the registered state and latched fields. There is no combinational path from inputs to outputs.
- Reset: every output is 0 and the state is IDLE on the first edge with `clear` = 1. `clear` overrides `start` and aborts any operation mid-sequence. The next cycle shows all strobes 0, and no `done` or `err` is emitted.
- With `start` sampled at edge 0:
  - Binary op: T_Y in cycle 1, T_OP in cycle 2, T_WB plus `done` in cycle 3. Latency is 3 cycles; `busy` is high in cycles 1–3.
  - Unary op: T_OP in cycle 1, T_WB plus `done` in cycle 2.
  - MUL/DIV: cycles 1–4, with `done` in cycle 4.
  - Illegal op: ERR in cycle 1.
- Back-to-back: a `start` held high is re-sampled in the IDLE cycle after `done`. Maximum throughput is one binary op per 4 cycles.
- `start` while `busy` = 1 is ignored and not queued.

## Configuration
- Macro: `ALU_SEQ_MULDIV_EN`.
- Defined: MUL/DIV take the 4-state path (T_Y, T_OP, T_WB, T_WB_HI) with Z-high capture and the HI/LO writeback.
- Undefined: 5'b01111 and 5'b10000 are classed illegal (→ ERR, `err` pulse). `ZHighin`, `Zhighout`, `HIin` and `LOin` are tied to 0, and the T_WB_HI state is not built.

## Test plan
- ROL, `opcode`=5'b00110, `rb`=3, `rc`=2, `ra`=1, start at cycle 0:
  - cycle 1: `Rout`=16'h0008, `Yin`=1.
  - cycle 2: `Rout`=16'h0004, `Zlowin`=1, `op`=5'b00110.
  - cycle 3: `Zlowout`=1, `Rin`=16'h0002, `done`=1.
  - cycle 4: `busy`=0.
  - With `data_path` attached and R3=12, R2=5, the expected R1 value is checked against the team's ROL definition (ROL function/data_path model), not assumed.
- NOT, `rb`=4, `ra`=7:
  - cycle 1: `Rout`=16'h0010, `Zlowin`=1.
  - cycle 2: `Rin`=16'h0080, `done`=1.
  - `Yin` never asserts.
- MUL, `rb`=5, `rc`=6, macro defined:
  - cycle 2: `ZHighin`=`Zlowin`=1.
  - cycle 3: `LOin`=1, `Rin`=0.
  - cycle 4: `Zhighout`=`HIin`=`done`=1.
  - With the macro undefined, the same stimulus gives cycle 1 `err`=1 and no strobes.
- `opcode`=5'b11000 → cycle 1 `err`=1, `op`=0, all strobes 0; cycle 2 IDLE.
- `clear` asserted in T_OP of a binary op → next cycle all outputs 0, no `done`. A subsequent start runs normally.
- `start` held high for 10 cycles with binary ops → `done` at cycles 3 and 7. Changing `rb` in cycle 1 does not alter `Rout` in cycle 2.
